// File: rtl/tt_um_led_pwm_bank_jellyant.sv
// Multi-channel LED PWM bank for a TinyTapeout user slot.
// Duties are written through a synchronised strobe/ack handshake into shadow
// registers and copied to the active set only at a PWM period boundary, so a
// running period is never glitched. Global invert and blink gating apply
// immediately (after synchronisation) without waiting for the period end.
module tt_um_led_pwm_bank_jellyant #(
  parameter int CH            = 8,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE      = 4,
  parameter int BLINK_PERIODS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BL_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [BL_W-1:0]     BL_LAST  = BL_W'(BLINK_PERIODS - 1);
  // The counter runs 0..MAX-1 so that a duty of MAX keeps the output solidly on.
  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((1 << PWM_BITS) - 2);

  // Synchronised control pins: bit0 strobe, bit1 invert, bit2 blink enable.
  logic [2:0]          sync1_q, sync2_q;
  logic                strobe_dly_q;
  logic [PS_W-1:0]     presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [BL_W-1:0]     blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [PWM_BITS-1:0] shadow_q [CH];
  logic [PWM_BITS-1:0] shadow_d [CH];
  logic [PWM_BITS-1:0] active_q [CH];
  logic [PWM_BITS-1:0] active_d [CH];
  logic [CH-1:0]       out_q, out_d;
  logic                ack_q, pstart_q;

  logic strobe_rise, addr_ok, wr, tick, pend, invert_s, blink_en_s, blank;

  // Upper duty bits (when PWM_BITS < 8) and uio_in[7:6] are deliberately ignored.
  wire unused_ok = &{1'b0, ui_in, uio_in[7:6]};

  assign strobe_rise = sync2_q[0] & ~strobe_dly_q;
  assign invert_s    = sync2_q[1];
  assign blink_en_s  = sync2_q[2];
  assign addr_ok     = ({1'b0, uio_in[2:0]} < 4'(CH));
  assign wr          = strobe_rise & addr_ok;
  assign tick        = ena & (presc_q == PS_LAST);
  assign pend        = tick & (pwm_cnt_q == CNT_LAST);
  assign blank       = blink_en_s & ~blink_phase_q;

  // Next-state for timebase, blink, duty buffers and channel outputs.
  always_comb begin
    presc_d       = presc_q;
    pwm_cnt_d     = pwm_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    out_d         = '0;
    if (ena) presc_d = (presc_q == PS_LAST) ? '0 : presc_q + 1'b1;
    if (tick) pwm_cnt_d = (pwm_cnt_q == CNT_LAST) ? '0 : pwm_cnt_q + 1'b1;
    for (int i = 0; i < CH; i++) begin
      if (wr && (uio_in[2:0] == 3'(i))) shadow_d[i] = ui_in[PWM_BITS-1:0];
    end
    // A write landing on the boundary edge is taken into the new period.
    if (pend) begin
      active_d = shadow_d;
      if (blink_cnt_q == BL_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
    for (int i = 0; i < CH; i++) begin
      out_d[i] = ((pwm_cnt_q < active_q[i]) & ~blank) ^ invert_s;
    end
  end

  // All state registers; everything clears asynchronously on rst_n low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      strobe_dly_q  <= 1'b0;
      presc_q       <= '0;
      pwm_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      out_q         <= '0;
      ack_q         <= 1'b0;
      pstart_q      <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      sync1_q       <= uio_in[5:3];
      sync2_q       <= sync1_q;
      strobe_dly_q  <= sync2_q[0];
      presc_q       <= presc_d;
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      out_q         <= out_d;
      ack_q         <= wr;
      pstart_q      <= pend;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
    end
  end

  // Pin mapping: unused channel outputs are tied low.
  always_comb begin
    uo_out         = '0;
    uo_out[CH-1:0] = out_q;
  end

  assign uio_out = {pstart_q, ack_q, 6'b00_0000};
  assign uio_oe  = 8'b1100_0000;

endmodule

// File: tb/tb_tt_um_led_pwm_bank_jellyant.sv
// Directed bench for the LED PWM bank: main instance with 6 channels,
// 8-bit duty, prescale 1, blink every 2 periods; a second small instance
// (1 channel, 2-bit duty, prescale 3) exercises the prescaler.
module tb_tt_um_led_pwm_bank_jellyant;

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [7:0] ui_in, uio_in;
  wire  [7:0] uo_out, uio_out, uio_oe;
  wire  [7:0] uo2, uio2, oe2;

  int tests = 0;
  int fails = 0;
  int cnt[8];
  int npulse;
  int last_pulse;

  always #5 clk = ~clk;

  tt_um_led_pwm_bank_jellyant #(
    .CH(6), .PWM_BITS(8), .PRESCALE(1), .BLINK_PERIODS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  tt_um_led_pwm_bank_jellyant #(
    .CH(1), .PWM_BITS(2), .PRESCALE(3), .BLINK_PERIODS(1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo2), .uio_out(uio2), .uio_oe(oe2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d,
                          output int ack_at, output int nack);
    ui_in       = d;
    uio_in[2:0] = a;
    uio_in[3]   = 1'b1;
    ack_at = -1;
    nack   = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (uio_out[6]) begin
        nack++;
        if (ack_at < 0) ack_at = k;
      end
    end
    uio_in[3] = 1'b0;
    for (int k = 0; k < 4; k++) step();
  endtask

  task automatic wait_pulse(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      step();
      if (uio_out[7]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Count high cycles per channel over one full 255-cycle period.
  task automatic measure();
    npulse = 0;
    for (int c = 0; c < 8; c++) cnt[c] = 0;
    for (int k = 0; k < 255; k++) begin
      step();
      for (int c = 0; c < 8; c++) cnt[c] += int'(uo_out[c]);
      npulse += int'(uio_out[7]);
    end
    last_pulse = int'(uio_out[7]);
  endtask

  task automatic test_reset();
    bit bad = 1'b0;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    for (int k = 0; k < 10; k++) begin
      step();
      if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'hC0) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL reset_outputs uo=%h uio=%h oe=%h required 00/00/C0", uo_out, uio_out, uio_oe);
    end
    tests++;
    if (uo2 !== 8'h00 || uio2 !== 8'h00 || oe2 !== 8'hC0) begin
      fails++;
      $display("FAIL reset_small uo=%h uio=%h oe=%h required 00/00/C0", uo2, uio2, oe2);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    int a, n;
    bit bad = 1'b0;
    bit seen = 1'b0;
    int others = 0;
    do_write(3'd2, 8'h40, a, n);
    tests++;
    if (a !== 3 || n !== 1) begin
      fails++;
      $display("FAIL ack_timing at=%0d count=%0d required at=3 count=1", a, n);
    end
    for (int k = 0; k < 300; k++) begin
      step();
      if (uio_out[7]) begin
        seen = 1'b1;
        break;
      end
      if (uo_out !== 8'h00) bad = 1'b1;
    end
    tests++;
    if (bad || !seen) begin
      fails++;
      $display("FAIL pre_period_quiet glitch=%0d pulse_seen=%0d required 0/1", bad, seen);
    end
    measure();
    tests++;
    if (cnt[2] !== 64) begin
      fails++;
      $display("FAIL ch2_duty high=%0d required 64", cnt[2]);
    end
    for (int c = 0; c < 8; c++) if (c != 2) others += cnt[c];
    tests++;
    if (others !== 0 || npulse !== 1 || last_pulse !== 1) begin
      fails++;
      $display("FAIL period_shape others=%0d pulses=%0d last=%0d required 0/1/1", others, npulse, last_pulse);
    end
  endtask

  task automatic test_multi();
    int a, n;
    bit ok;
    int exp_c[8] = '{0, 255, 64, 0, 0, 128, 0, 0};
    do_write(3'd0, 8'h00, a, n);
    do_write(3'd1, 8'hFF, a, n);
    do_write(3'd5, 8'h80, a, n);
    tests++;
    if (a !== 3 || n !== 1) begin
      fails++;
      $display("FAIL ack_ch5 at=%0d count=%0d required at=3 count=1", a, n);
    end
    wait_pulse(600, ok);
    measure();
    for (int c = 0; c < 8; c++) begin
      tests++;
      if (!ok || cnt[c] !== exp_c[c]) begin
        fails++;
        $display("FAIL multi_duty ch%0d high=%0d required %0d", c, cnt[c], exp_c[c]);
      end
    end
  endtask

  task automatic test_bad_addr();
    int a7, n7, a6, n6;
    bit ok;
    int exp_c[8] = '{0, 255, 64, 0, 0, 128, 0, 0};
    bit bad = 1'b0;
    do_write(3'd7, 8'h99, a7, n7);
    do_write(3'd6, 8'h11, a6, n6);
    tests++;
    if (n7 !== 0 || n6 !== 0) begin
      fails++;
      $display("FAIL bad_addr_ack acks=%0d/%0d required 0/0", n7, n6);
    end
    wait_pulse(600, ok);
    measure();
    for (int c = 0; c < 8; c++) if (cnt[c] !== exp_c[c]) bad = 1'b1;
    tests++;
    if (!ok || bad) begin
      fails++;
      $display("FAIL bad_addr_outputs ch5=%0d ch2=%0d required 128/64", cnt[5], cnt[2]);
    end
  endtask

  task automatic test_invert();
    bit ok;
    int exp_c[8] = '{255, 0, 191, 255, 255, 127, 0, 0};
    bit bad = 1'b0;
    uio_in[4] = 1'b1;
    step();
    step();
    tests++;
    if (uo_out[1:0] !== 2'b10) begin
      fails++;
      $display("FAIL invert_early uo[1:0]=%b required 10", uo_out[1:0]);
    end
    step();
    tests++;
    if (uo_out[1:0] !== 2'b01 || uo_out[7:6] !== 2'b00) begin
      fails++;
      $display("FAIL invert_third_cycle uo=%b required xxxxxx01 with [7:6]=00", uo_out);
    end
    wait_pulse(600, ok);
    measure();
    for (int c = 0; c < 8; c++) if (cnt[c] !== exp_c[c]) bad = 1'b1;
    tests++;
    if (!ok || bad) begin
      fails++;
      $display("FAIL invert_period ch0=%0d ch2=%0d ch5=%0d ch7=%0d required 255/191/127/0",
               cnt[0], cnt[2], cnt[5], cnt[7]);
    end
    uio_in[4] = 1'b0;
    for (int k = 0; k < 3; k++) step();
  endtask

  task automatic test_blink();
    bit prev;
    bit found = 1'b0;
    int ones = 1;
    int zeros = 1;
    uio_in[5] = 1'b1;
    prev = uo_out[1];
    for (int k = 0; k < 1600; k++) begin
      step();
      if (!prev && uo_out[1]) begin
        found = 1'b1;
        break;
      end
      prev = uo_out[1];
    end
    for (int k = 0; k < 600; k++) begin
      step();
      if (uo_out[1]) ones++;
      else break;
    end
    for (int k = 0; k < 600; k++) begin
      step();
      if (!uo_out[1]) zeros++;
      else break;
    end
    tests++;
    if (!found || ones !== 510) begin
      fails++;
      $display("FAIL blink_on found=%0d on_cycles=%0d required 1/510", found, ones);
    end
    tests++;
    if (zeros !== 510) begin
      fails++;
      $display("FAIL blink_off off_cycles=%0d required 510", zeros);
    end
    uio_in[5] = 1'b0;
    for (int k = 0; k < 3; k++) step();
  endtask

  task automatic test_ena_freeze();
    bit ok;
    bit bad = 1'b0;
    logic [7:0] snap;
    int resume = -1;
    wait_pulse(600, ok);
    for (int k = 0; k < 100; k++) step();
    ena = 1'b0;
    step();
    snap = uo_out;
    tests++;
    if (!ok || snap !== 8'h22) begin
      fails++;
      $display("FAIL freeze_value uo=%h required 22", snap);
    end
    for (int k = 0; k < 99; k++) begin
      step();
      if (uo_out !== snap || uio_out[7]) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL freeze_hold uo=%h required %h", uo_out, snap);
    end
    ena = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      step();
      if (uio_out[7]) begin
        resume = k;
        break;
      end
    end
    tests++;
    if (resume !== 155) begin
      fails++;
      $display("FAIL freeze_resume cycles_to_period=%0d required 155", resume);
    end
  endtask

  task automatic test_small_config();
    int a, n;
    bit seen = 1'b0;
    int high = 0;
    int pulses = 0;
    int gap = -1;
    do_write(3'd0, 8'h02, a, n);
    for (int k = 0; k < 40; k++) begin
      step();
      if (uio2[7]) begin
        seen = 1'b1;
        break;
      end
    end
    for (int k = 1; k <= 9; k++) begin
      step();
      high += int'(uo2[0]);
      if (uio2[7]) begin
        pulses++;
        gap = k;
      end
    end
    tests++;
    if (!seen || pulses !== 1 || gap !== 9) begin
      fails++;
      $display("FAIL small_period pulses=%0d gap=%0d required 1/9", pulses, gap);
    end
    tests++;
    if (high !== 6 || uo2[7:1] !== 7'd0) begin
      fails++;
      $display("FAIL small_duty high=%0d upper=%b required 6/0000000", high, uo2[7:1]);
    end
  endtask

  task automatic test_async_reset();
    bit bad = 1'b0;
    int first = -1;
    step();
    tests++;
    if (uo_out[1] !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_ch1 uo[1]=%b required 1", uo_out[1]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00 || uo2 !== 8'h00) begin
      fails++;
      $display("FAIL async_reset uo=%h uio=%h uo2=%h required 00/00/00", uo_out, uio_out, uo2);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      step();
      if (uo_out !== 8'h00) bad = 1'b1;
      if (uio_out[7]) begin
        first = k;
        break;
      end
    end
    tests++;
    if (bad || first !== 255) begin
      fails++;
      $display("FAIL restart_period glitch=%0d first_pulse=%0d required 0/255", bad, first);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_multi();
    test_bad_addr();
    test_invert();
    test_blink();
    test_ena_freeze();
    test_small_config();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/tt_um_led_pwm_bank_jellyant.md
Name: tt_um_led_pwm_bank_jellyant

Overview:
Parametrised successor to our single-LED inverter top. It drives up to 8 LED channels, each with an independently programmable PWM duty cycle. Duties are written through the dedicated inputs using a strobe-and-acknowledge handshake and are double-buffered so that a change never glitches a running period. Optional global inversion and blink gating are provided. The block is a TinyTapeout user top: the standard 8-bit ui/uo/uio pin set plus clk, rst_n and ena.

Parameters:
CH, 8, number of PWM channels (1..8); uo_out[7:CH] tied 0
PWM_BITS, 8, duty resolution (2..8); duty taken from ui_in[PWM_BITS-1:0]
PRESCALE, 4, clk cycles per PWM step (>=1)
BLINK_PERIODS, 16, PWM periods per blink half-phase (>=1)

Ports:
clk  input  1  system clock, single domain
rst_n  input  1  asynchronous active-low reset
ena  input  1  0 freezes prescaler, PWM counter and blink counter; writes still accepted
ui_in  input  8  duty value for write
uio_in  input  8  [2:0] channel address, [3] write strobe, [4] invert, [5] blink enable, [7:6] unused
uo_out  output  8  [CH-1:0] PWM outputs, rest 0
uio_out  output  8  [6] write ack, [7] period-start pulse, [5:0] 0
uio_oe  output  8  constant 8'b1100_0000

Behaviour:
- Decided: one clock clk; reset rst_n asynchronous, active-low; all flops clear on rst_n low.
- Reset values: uo_out=0, uio_out=0, all shadow and active duties 0, prescaler=0, pwm_cnt=0, blink_cnt=0, blink_phase=1 (on), synchronisers 0.
- uio_in[5:3] each pass through a 2-FF synchroniser. A write fires on a rising edge of the synchronised strobe (sync_q & ~sync_q_d).
- On write: if addr<CH, shadow[addr] <= ui_in[PWM_BITS-1:0], sampled in the detect cycle; ui_in and addr must be held stable from strobe rise until the ack. uio_out[6] is high for exactly 1 cycle, the cycle after the shadow write. If addr>=CH: no write, no ack.
- MAX = 2^PWM_BITS-1. tick = ena & (prescaler==PRESCALE-1). Prescaler wraps to 0 on tick and holds while ena=0.
- On tick: pwm_cnt <= (pwm_cnt==MAX-1) ? 0 : pwm_cnt+1. Period = MAX*PRESCALE clk cycles (default 1020).
- Period end (tick & pwm_cnt==MAX-1): active[i] <= shadow[i] for all i, in the same edge, including a shadow write landing that cycle. uio_out[7] is high for 1 cycle on the next edge.
- Blink: at each period end, blink_cnt increments. At BLINK_PERIODS-1 it wraps to 0 and blink_phase toggles.
- Output, registered: raw[i] = (pwm_cnt < active[i]) & ~(blink_en & ~blink_phase); uo_out[i] <= raw[i] ^ invert. One cycle latency from pwm_cnt.
- Duty 0 gives raw always 0. Duty MAX gives raw always 1 (pwm_cnt never reaches MAX).
- Invert or blink toggles take effect 3 cycles after the pin change (2 sync + output reg), mid-period, without waiting for the period end.
- Mid-period writes do not change outputs until the next period end. Back-to-back writes to the same channel: last one before the period end wins.
- Async reset mid-period: outputs go 0 immediately; the first period restarts from pwm_cnt=0 with active=0.

Test Plan:
- Reset with PRESCALE=1, PWM_BITS=8, hold 10 cycles -> uo_out=0x00, uio_out=0x00, uio_oe=0xC0 throughout.
- Write ch2=64 (addr=2, ui_in=0x40, strobe rise) -> one ack pulse 3 cycles after strobe; uo_out[2] stays 0 until next period pulse, then high for exactly 64 of each 255 cycles.
- Write ch0=0, ch1=255, ch7=128 -> after period end uo_out[0] constant 0, uo_out[1] constant 1, uo_out[7] high 128/255 cycles.
- Write addr=5 with CH=4 -> no ack, no output change. Assert invert -> uo_out[3:0] all flip 3 cycles later; uo_out[7:4] stay 0.
- Blink enable with BLINK_PERIODS=2, ch1=255 -> uo_out[1] is 1 for 510 cycles then 0 for 510, repeating.
- ena=0 for 100 cycles mid-period -> pwm_cnt and outputs frozen; resume continues exactly from the held count. Assert rst_n low mid-period -> uo_out=0 with no clk edge needed.
